// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_if
// Purpose  : Bundles the three buses seen by the load/store stage: the EXU
//            instruction handshake, the data-memory req/ack bus and the
//            write-back payload towards the WBU.
// Modports : master - the load/store unit (drives lsu_ready, mem_*, WBU payload)
//            slave  - the surrounding core/memory (drives exu_*, mem_ack,
//                     mem_rdata, wbu_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if #(
   parameter int ADDR_W = 32
);
   // EXU -> LSU
   logic              exu_valid;
   logic              lsu_ready;
   logic [31:0]       exu_res;
   logic [31:0]       exu_wdata;
   logic              exu_memread;
   logic              exu_memwrite;
   logic [2:0]        exu_funct3;
   logic              exu_regw;
   // LSU <-> data memory
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   // LSU -> WBU
   logic              wbu_valid;
   logic              wbu_ready;
   logic [31:0]       res;
   logic [31:0]       dataout;
   logic              memtoreg;
   logic              regw;

   modport master (
      input  exu_valid, exu_res, exu_wdata, exu_memread, exu_memwrite,
             exu_funct3, exu_regw, mem_ack, mem_rdata, wbu_ready,
      output lsu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
             wbu_valid, res, dataout, memtoreg, regw
   );

   modport slave (
      output exu_valid, exu_res, exu_wdata, exu_memread, exu_memwrite,
             exu_funct3, exu_regw, mem_ack, mem_rdata, wbu_ready,
      input  lsu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
             wbu_valid, res, dataout, memtoreg, regw
   );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store stage of the multi-cycle core. Accepts one EXU
//            instruction at a time, performs at most one data-memory access,
//            aligns/extends load data and hands the result to the WBU.
// Ports    : clk  - clock
//            rst  - synchronous, active-low reset
//            bus  - lsu_ctrl_if.master (EXU handshake, memory bus, WBU payload)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
   parameter int ADDR_W = 32
) (
   input  wire logic    clk,
   input  wire logic    rst,
   lsu_ctrl_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_lsu_ready;
   logic              r_wbu_valid;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_wmask;
   logic [31:0]       r_res;
   logic [31:0]       r_dataout;
   logic              r_memtoreg;
   logic              r_regw;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;

   logic [31:0]       w_st_wdata;
   logic [3:0]        w_st_wmask;
   logic [7:0]        w_ld_byte;
   logic [15:0]       w_ld_half;
   logic [31:0]       w_ld_data;
   logic              w_is_mem;

   assign w_is_mem = bus.exu_memread | bus.exu_memwrite;

   // Store lane steering, computed from the offered instruction so it can
   // be registered at accept time and held unchanged through MEM.
   always_comb begin
      w_st_wdata = bus.exu_wdata;
      w_st_wmask = 4'b1111;
      case (bus.exu_funct3)
         3'b000: begin
            w_st_wdata = {4{bus.exu_wdata[7:0]}};
            w_st_wmask = 4'b0001 << bus.exu_res[1:0];
         end
         3'b001: begin
            w_st_wdata = {2{bus.exu_wdata[15:0]}};
            w_st_wmask = bus.exu_res[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Load alignment uses the offset/size latched at accept time.
   always_comb begin
      w_ld_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
      w_ld_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b100:  w_ld_data = {24'd0, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b101:  w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_lsu_ready <= 1'b1;
         r_wbu_valid <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_mem_wmask <= 4'd0;
         r_res       <= 32'd0;
         r_dataout   <= 32'd0;
         r_memtoreg  <= 1'b0;
         r_regw      <= 1'b0;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.exu_valid) begin
                  r_res       <= bus.exu_res;
                  r_regw      <= bus.exu_regw;
                  // A combined read+write request is executed as a store.
                  r_memtoreg  <= bus.exu_memread & ~bus.exu_memwrite;
                  r_mem_we    <= bus.exu_memwrite;
                  r_mem_addr  <= {bus.exu_res[ADDR_W-1:2], 2'b00};
                  r_mem_wdata <= w_st_wdata;
                  r_mem_wmask <= bus.exu_memwrite ? w_st_wmask : 4'd0;
                  r_funct3    <= bus.exu_funct3;
                  r_off       <= bus.exu_res[1:0];
                  r_dataout   <= 32'd0;
                  r_lsu_ready <= 1'b0;
                  if (w_is_mem) begin
                     r_state   <= S_MEM;
                     r_mem_req <= 1'b1;
                  end else begin
                     r_state     <= S_WB;
                     r_wbu_valid <= 1'b1;
                  end
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  if (r_memtoreg) begin
                     r_dataout <= w_ld_data;
                  end
                  r_state     <= S_WB;
                  r_mem_req   <= 1'b0;
                  r_wbu_valid <= 1'b1;
               end
            end
            S_WB: begin
               if (bus.wbu_ready) begin
                  r_state     <= S_IDLE;
                  r_wbu_valid <= 1'b0;
                  r_lsu_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_lsu_ready <= 1'b1;
               r_wbu_valid <= 1'b0;
               r_mem_req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.lsu_ready = r_lsu_ready;
   assign bus.wbu_valid = r_wbu_valid;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wmask = r_mem_wmask;
   assign bus.res       = r_res;
   assign bus.dataout   = r_dataout;
   assign bus.memtoreg  = r_memtoreg;
   assign bus.regw      = r_regw;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Directed self-checking bench for lsu_ctrl. Drives the EXU side,
//            acts as data memory (with a small word store) and as the WBU.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [31:0] mem_model [0:15];

   lsu_ctrl_if #(.ADDR_W(32)) bus ();

   lsu_ctrl #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] res, input logic [31:0] wdata,
                        input logic rd, input logic wr,
                        input logic [2:0] f3, input logic rw);
      int guard;
      guard = 0;
      bus.exu_res      = res;
      bus.exu_wdata    = wdata;
      bus.exu_memread  = rd;
      bus.exu_memwrite = wr;
      bus.exu_funct3   = f3;
      bus.exu_regw     = rw;
      bus.exu_valid    = 1'b1;
      while (bus.lsu_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_tests++;
      if (guard >= 20) begin
         n_fail++;
         $display("FAIL issue_timeout: lsu_ready=%b, required 1 within 20 cycles", bus.lsu_ready);
      end
      tick();
      bus.exu_valid = 1'b0;
   endtask

   // Memory responder: k idle cycles, then one ack cycle (writes update the model).
   task automatic serve(input int k, input logic [31:0] rd);
      bus.mem_ack = 1'b0;
      repeat (k) tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      if (bus.mem_we === 1'b1) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_wmask[b])
               mem_model[bus.mem_addr[5:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
         end
      end
      tick();
      bus.mem_ack = 1'b0;
   endtask

   task automatic wb_accept();
      bus.wbu_ready = 1'b1;
      tick();
      bus.wbu_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lsu_ready got=%b exp=1", bus.lsu_ready); end
      n_tests++; if (bus.wbu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wbu_valid got=%b exp=0", bus.wbu_valid); end
      n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
      n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
      n_tests++; if ({bus.memtoreg, bus.regw} !== 2'b00) begin n_fail++; $display("FAIL rst_memtoreg_regw got=%b exp=00", {bus.memtoreg, bus.regw}); end
      n_tests++; if (bus.mem_wmask !== 4'd0) begin n_fail++; $display("FAIL rst_wmask got=%b exp=0000", bus.mem_wmask); end
      n_tests++; if ((bus.res | bus.dataout | bus.mem_addr | bus.mem_wdata) !== 32'd0) begin
         n_fail++; $display("FAIL rst_data got res=%h dout=%h addr=%h wdata=%h exp all 0", bus.res, bus.dataout, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_mem();
      issue(32'h8000_0010, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1);
      n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midmem_req got=%b exp=1", bus.mem_req); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL midmem_req_after_rst got=%b exp=0", bus.mem_req); end
      n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL midmem_ready_after_rst got=%b exp=1", bus.lsu_ready); end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h5555_5555;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      n_tests++; if (bus.wbu_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ack_wbu_valid got=%b exp=0", bus.wbu_valid); end
      n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ack_ready got=%b exp=1", bus.lsu_ready); end
   endtask

   task automatic test_alu();
      issue(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b000, 1'b1);
      n_tests++; if (bus.wbu_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wbu_valid got=%b exp=1", bus.wbu_valid); end
      n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL alu_mem_req got=%b exp=0", bus.mem_req); end
      n_tests++; if (bus.dataout !== 32'd0) begin n_fail++; $display("FAIL alu_dataout got=%h exp=0", bus.dataout); end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (bus.wbu_valid !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_fail++; $display("FAIL alu_hold_valid cyc%0d got valid=%b ready=%b exp 1/0", i, bus.wbu_valid, bus.lsu_ready);
         end
         n_tests++; if (bus.res !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_res cyc%0d got=%h exp=12345678", i, bus.res); end
         n_tests++; if ({bus.memtoreg, bus.regw} !== 2'b01) begin n_fail++; $display("FAIL alu_flags cyc%0d got=%b exp=01", i, {bus.memtoreg, bus.regw}); end
         tick();
      end
      wb_accept();
      n_tests++; if (bus.lsu_ready !== 1'b1 || bus.wbu_valid !== 1'b0) begin
         n_fail++; $display("FAIL alu_return_idle got ready=%b valid=%b exp 1/0", bus.lsu_ready, bus.wbu_valid);
      end
   endtask

   task automatic test_stores();
      issue(32'h8000_0003, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL sb_req_we cyc%0d got req=%b we=%b exp 1/1", i, bus.mem_req, bus.mem_we);
         end
         n_tests++; if (bus.mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sb_addr got=%h exp=80000000", bus.mem_addr); end
         n_tests++; if (bus.mem_wmask !== 4'b1000) begin n_fail++; $display("FAIL sb_wmask got=%b exp=1000", bus.mem_wmask); end
         n_tests++; if (bus.mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata got=%h exp=abababab", bus.mem_wdata); end
         tick();
      end
      serve(0, 32'h1111_1111);
      n_tests++; if (bus.wbu_valid !== 1'b1 || bus.memtoreg !== 1'b0) begin
         n_fail++; $display("FAIL sb_wb got valid=%b memtoreg=%b exp 1/0", bus.wbu_valid, bus.memtoreg);
      end
      n_tests++; if (bus.dataout !== 32'd0) begin n_fail++; $display("FAIL sb_dataout got=%h exp=0", bus.dataout); end
      wb_accept();
      // SH to upper half; read+write both set must behave as a store
      issue(32'h8000_0012, 32'h1234_CDEF, 1'b1, 1'b1, 3'b001, 1'b0);
      n_tests++; if (bus.mem_wmask !== 4'b1100) begin n_fail++; $display("FAIL sh_wmask got=%b exp=1100", bus.mem_wmask); end
      n_tests++; if (bus.mem_wdata !== 32'hCDEF_CDEF) begin n_fail++; $display("FAIL sh_wdata got=%h exp=cdefcdef", bus.mem_wdata); end
      n_tests++; if (bus.mem_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL sh_addr got=%h exp=80000010", bus.mem_addr); end
      serve(1, 32'h2222_2222);
      n_tests++; if (bus.memtoreg !== 1'b0 || bus.dataout !== 32'd0) begin
         n_fail++; $display("FAIL rdwr_as_store got memtoreg=%b dout=%h exp 0/0", bus.memtoreg, bus.dataout);
      end
      wb_accept();
   endtask

   task automatic test_half_loads();
      logic [2:0]  f3s  [2];
      logic [31:0] exps [2];
      f3s[0] = 3'b001; exps[0] = 32'hFFFF_8001;
      f3s[1] = 3'b101; exps[1] = 32'h0000_8001;
      for (int t = 0; t < 2; t++) begin
         issue(32'h8000_0002, 32'd0, 1'b1, 1'b0, f3s[t], 1'b1);
         n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_wmask !== 4'd0) begin
            n_fail++; $display("FAIL ld_we_mask t%0d got we=%b mask=%b exp 0/0000", t, bus.mem_we, bus.mem_wmask);
         end
         bus.mem_ack = 1'b0;
         for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.mem_req !== 1'b1 || bus.wbu_valid !== 1'b0) begin
               n_fail++; $display("FAIL ld_wait t%0d cyc%0d got req=%b valid=%b exp 1/0", t, i, bus.mem_req, bus.wbu_valid);
            end
            tick();
         end
         serve(0, 32'h8001_1234);
         n_tests++; if (bus.wbu_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL ld_wb_rise t%0d got valid=%b req=%b exp 1/0", t, bus.wbu_valid, bus.mem_req);
         end
         n_tests++; if (bus.dataout !== exps[t]) begin n_fail++; $display("FAIL ld_half_data t%0d got=%h exp=%h", t, bus.dataout, exps[t]); end
         n_tests++; if (bus.memtoreg !== 1'b1) begin n_fail++; $display("FAIL ld_memtoreg t%0d got=%b exp=1", t, bus.memtoreg); end
         wb_accept();
      end
   endtask

   task automatic test_lb_lw();
      issue(32'h8000_0001, 32'd0, 1'b1, 1'b0, 3'b000, 1'b1);
      serve(2, 32'h0000_FF00);
      n_tests++; if (bus.dataout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb_data got=%h exp=ffffffff", bus.dataout); end
      wb_accept();
      issue(32'h8000_0001, 32'd0, 1'b1, 1'b0, 3'b100, 1'b1);
      serve(1, 32'h0000_FF00);
      n_tests++; if (bus.dataout !== 32'h0000_00FF) begin n_fail++; $display("FAIL lbu_data got=%h exp=000000ff", bus.dataout); end
      wb_accept();
      // LW with ack in the first request cycle, misaligned address ignored
      issue(32'h8000_0007, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1);
      n_tests++; if (bus.mem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL lw_addr got=%h exp=80000004", bus.mem_addr); end
      n_tests++; if (bus.wbu_valid !== 1'b0) begin n_fail++; $display("FAIL lw_early_valid got=%b exp=0", bus.wbu_valid); end
      serve(0, 32'hDEAD_BEEF);
      n_tests++; if (bus.wbu_valid !== 1'b1) begin n_fail++; $display("FAIL lw_k0_valid got=%b exp=1", bus.wbu_valid); end
      n_tests++; if (bus.dataout !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data got=%h exp=deadbeef", bus.dataout); end
      wb_accept();
   endtask

   task automatic test_back_to_back();
      logic exp_rdy [4];
      exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b1;
      bus.wbu_ready = 1'b1;
      issue(32'h8000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 1'b0);
      n_tests++; if (bus.mem_wmask !== 4'b1111 || bus.lsu_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_sw got mask=%b ready=%b exp 1111/0", bus.mem_wmask, bus.lsu_ready);
      end
      serve(0, 32'd0);
      n_tests++; if (bus.wbu_valid !== 1'b1 || bus.lsu_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_sw_wb got valid=%b ready=%b exp 1/0", bus.wbu_valid, bus.lsu_ready);
      end
      bus.exu_res = 32'h8000_0008; bus.exu_memread = 1'b1; bus.exu_memwrite = 1'b0;
      bus.exu_funct3 = 3'b010; bus.exu_regw = 1'b1; bus.exu_valid = 1'b1;
      tick();
      n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready got=%b exp=1", bus.lsu_ready); end
      tick();
      bus.exu_valid = 1'b0;
      n_tests++; if (bus.mem_req !== 1'b1 || bus.lsu_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_lw_req got req=%b ready=%b exp 1/0", bus.mem_req, bus.lsu_ready);
      end
      serve(0, mem_model[bus.mem_addr[5:2]]);
      n_tests++; if (bus.dataout !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_lw_data got=%h exp=cafef00d", bus.dataout); end
      tick();
      n_tests++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_lw_done_ready got=%b exp=1", bus.lsu_ready); end
      // Streaming ALU ops: one accept every two cycles
      bus.exu_memread = 1'b0; bus.exu_res = 32'h0000_0042; bus.exu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++; if (bus.lsu_ready !== exp_rdy[i]) begin
            n_fail++; $display("FAIL b2b_alu_ready cyc%0d got=%b exp=%b", i, bus.lsu_ready, exp_rdy[i]);
         end
      end
      bus.exu_valid = 1'b0;
      tick();
      bus.wbu_ready = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 16; i++) mem_model[i] = 32'd0;
      rst              = 1'b0;
      bus.exu_valid    = 1'b0;
      bus.exu_res      = 32'd0;
      bus.exu_wdata    = 32'd0;
      bus.exu_memread  = 1'b0;
      bus.exu_memwrite = 1'b0;
      bus.exu_funct3   = 3'd0;
      bus.exu_regw     = 1'b0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = 32'd0;
      bus.wbu_ready    = 1'b0;

      test_reset();
      test_reset_mid_mem();
      test_alu();
      test_stores();
      test_half_loads();
      test_lb_lw();
      test_back_to_back();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store stage of the multi-cycle core. It sits between the execute unit (EXU) and the write-back unit (WBU). It accepts one instruction at a time from the EXU over a valid/ready handshake, performs at most one data-memory access over a req/ack bus, and aligns and extends load data. It then drives the WBU payload (`res`, `dataout`, `memtoreg`, `regw`) with `wbu_valid`, holding it until `wbu_ready` is seen.

## Interface
- ADDR_W, 32, width of data-memory address.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- exu_valid  in  1  EXU offers an instruction.
- lsu_ready  out  1  LSU can accept an instruction this cycle.
- exu_res  in  32  ALU result; effective address for memory ops.
- exu_wdata  in  32  store data (rs2).
- exu_memread  in  1  instruction is a load.
- exu_memwrite  in  1  instruction is a store.
- exu_funct3  in  3  access size/sign.
- exu_regw  in  1  instruction writes rd.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  word-aligned address (`exu_res` with bits [1:0] forced to 0).
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte-lane write enables.
- mem_ack  in  1  request complete; `mem_rdata` valid this cycle for reads.
- mem_rdata  in  32  read word.
- wbu_valid  out  1  payload to the WBU is valid.
- wbu_ready  in  1  WBU accepts the payload.
- res  out  32  latched `exu_res`.
- dataout  out  32  aligned/extended load data.
- memtoreg  out  1  latched `exu_memread`.
- regw  out  1  latched `exu_regw`.

## Operation
- States: IDLE, MEM, WB.
- `lsu_ready` is 1 only in IDLE. `wbu_valid` is 1 only in WB. `mem_req` is 1 only in MEM.
- Accepting an instruction (IDLE & `exu_valid`):
  - latch all `exu_*` inputs;
  - if `exu_memread` | `exu_memwrite`, go to MEM; otherwise go to WB.
- If `exu_memread` and `exu_memwrite` are both set, the instruction is treated as a store and `memtoreg` is 0.
- MEM:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wmask` are held stable until `mem_ack`.
  - On `mem_ack`, capture load data into `dataout` and go to WB.
- WB:
  - the payload is held stable;
  - on `wbu_ready`, go to IDLE.
- Offset: off = `exu_res[1:0]`.
- Loads, by funct3:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: half at off[1], sign-extended.
  - 101 LHU: half at off[1], zero-extended.
  - 010 and any other value: LW, full word.
- Stores, by funct3:
  - 000 SB: `mem_wmask` = 1<<off; `mem_wdata` = `wdata[7:0]` replicated on all 4 lanes.
  - 001 SH: `mem_wmask` = off[1] ? 1100 : 0011; `mem_wdata` = `wdata[15:0]` replicated on both halves.
  - 010 and any other value: SW, `mem_wmask` = 1111.
- Misalignment: half accesses ignore off[0]; word accesses ignore off. No exception is raised.
- `dataout` for a non-load instruction is 0.

## Timing
- Reset: `rst` low at a clk edge forces IDLE in every state, including mid-MEM and mid-WB. Outputs after that edge:
  - `lsu_ready` = 1;
  - `wbu_valid`, `mem_req`, `mem_we`, `memtoreg`, `regw` = 0;
  - `mem_wmask` = 0;
  - `res`, `dataout`, `mem_addr`, `mem_wdata` = 0.
- A `mem_ack` arriving outside MEM (for example a late ack after reset) is ignored.
- Non-memory instruction accepted at edge N: `wbu_valid` is high from cycle N+1.
- Memory instruction accepted at edge N:
  - `mem_req` is high from cycle N+1;
  - if `mem_ack` is sampled at edge N+1+k (k ≥ 0), `wbu_valid` is high from cycle N+2+k.
- `mem_ack` may arrive in the first `mem_req` cycle (k = 0).
- Accepting the WBU handshake at edge M returns to IDLE; `lsu_ready` is high in cycle M+1.
- Throughput: at most one instruction every 2 cycles (non-memory) or every 3+k cycles (memory).
- No combinational path from `wbu_ready` to `lsu_ready`, and none from `mem_ack` to `wbu_valid`.

## Test plan
- Reset mid-MEM: assert `rst` = 0 while `mem_req` = 1 → next cycle `mem_req` = 0 and `lsu_ready` = 1. A subsequent stray `mem_ack` produces no `wbu_valid`.
- ALU op, `exu_res` = 0x1234_5678, `exu_regw` = 1, `wbu_ready` held 0 for 3 cycles:
  - `wbu_valid` rises 1 cycle after accept;
  - `res` = 0x1234_5678, `memtoreg` = 0, `regw` = 1, all stable until `wbu_ready` = 1.
- SB to 0x8000_0003 with `exu_wdata` = 0x0000_00AB → `mem_addr` = 0x8000_0000, `mem_wmask` = 1000, `mem_wdata[31:24]` = 0xAB, `mem_we` = 1.
- Half loads at 0x8000_0002 with `mem_rdata` = 0x8001_1234, `mem_ack` delayed 4 cycles:
  - LH → `dataout` = 0xFFFF_8001;
  - LHU → `dataout` = 0x0000_8001;
  - `wbu_valid` rises 1 cycle after `mem_ack`.
- LB at offset 1 with `mem_rdata` = 0x0000_FF00 → `dataout` = 0xFFFF_FFFF. LW with same-cycle `mem_ack` (k = 0) → `dataout` = `mem_rdata`, `wbu_valid` 2 cycles after accept.
- Back-to-back: SW then LW to the same address, `wbu_ready` tied 1 → `lsu_ready` gaps are correct, and the LW returns the stored word from the memory model.
